// File: rtl/stream_mux_rr_if.sv
// Stream bundle between an N-channel source set and one output sink for stream_mux_rr.
// slave is the mux's view, master is the surrounding environment's view.
interface stream_mux_rr_if #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8
);
    localparam int CHW = $clog2(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_last;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_last;
    logic [CHW-1:0]        out_ch;
    logic                  out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_ch
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// Round-robin N-channel stream multiplexer with a single registered output stage.
// Optional packet lock (grant held until in_last) is enabled by STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    localparam int CHW  = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_mux_rr_if.slave  bus
);

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;
    logic [CHW-1:0]   out_ch_reg;
    logic [CHW-1:0]   last_grant_reg;

    logic             accept;
    logic             grant_found;
    logic [CHW-1:0]   grant_idx;
    logic [CHW-1:0]   cand_idx;
    logic [WIDTH-1:0] grant_data;
    logic             grant_last;
    logic [N_CH-1:0]  ready_mask;
    int               cand;

`ifdef STREAM_MUX_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state_reg;
`endif

    assign accept = !out_valid_reg || bus.out_ready;

    // Scan from farthest to nearest so the nearest valid channel after last_grant wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_reg;
        cand        = 0;
        cand_idx    = '0;
        for (int i = N_CH; i >= 1; i--) begin
            cand = int'(last_grant_reg) + i;
            if (cand >= N_CH)
                cand = cand - N_CH;
            cand_idx = CHW'(cand);
            if (bus.in_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        // While locked the grant stays on the packet owner, which is always last_grant.
        if (state_reg == LOCKED) begin
            grant_idx   = last_grant_reg;
            grant_found = bus.in_valid[last_grant_reg];
        end
`endif
    end

    always_comb begin
        grant_data = bus.in_data[grant_idx*WIDTH +: WIDTH];
        grant_last = bus.in_last[grant_idx];
        ready_mask = '0;
        if (rst_n && accept && grant_found)
            ready_mask[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
            out_ch_reg     <= '0;
            last_grant_reg <= CHW'(N_CH - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
            state_reg      <= IDLE;
`endif
        end else if (accept) begin
            out_valid_reg <= grant_found;
            if (grant_found) begin
                out_data_reg   <= grant_data;
                out_last_reg   <= grant_last;
                out_ch_reg     <= grant_idx;
                last_grant_reg <= grant_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
                case (state_reg)
                    IDLE:    if (!grant_last) state_reg <= LOCKED;
                    LOCKED:  if (grant_last)  state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
`endif
            end
        end
    end

    assign bus.in_ready  = ready_mask;
    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_ch    = out_ch_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: directed source queues, expected beats queued, monitor compares.
// Expectations for the lock scenario follow STREAM_MUX_PKT_LOCK_EN.
module tb_stream_mux_rr;
    localparam int N_CH  = 8;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b1;
    beat_t src_q[$];
    beat_t exp_q[$];
    int    xcyc[$];
    int    passed = 0;
    int    total  = 0;
    int    cyc    = 0;

    stream_mux_rr_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();
    stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic beat_t mk(input int ch, input int data, input bit last);
        beat_t b;
        b.ch   = 3'(ch);
        b.data = 8'(data);
        b.last = last;
        return b;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(exp_q.size() == 0, {name, "_drain"}, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_span(input string name, input int nbeats);
        int span;
        span = (xcyc.size() > 0) ? xcyc[xcyc.size()-1] - xcyc[0] : -1;
        chk(xcyc.size() == nbeats && span == nbeats - 1, name, span, nbeats - 1);
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(bus.out_valid == 1'b1, name, bus.out_valid, 1);
    endtask

    // Source driver: present the head beat of each channel, retire it after a handshake.
    initial begin
        logic [N_CH-1:0]       mask, v, l;
        logic [N_CH*WIDTH-1:0] d;
        mask = '0;
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.in_last  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N_CH; k++) begin
                if (mask[k]) begin
                    for (int j = 0; j < src_q.size(); j++) begin
                        if (src_q[j].ch == 3'(k)) begin
                            src_q.delete(j);
                            break;
                        end
                    end
                end
            end
            v = '0; l = '0; d = '0;
            for (int k = 0; k < N_CH; k++) begin
                for (int j = 0; j < src_q.size(); j++) begin
                    if (src_q[j].ch == 3'(k)) begin
                        v[k] = 1'b1;
                        d[k*WIDTH +: WIDTH] = src_q[j].data;
                        l[k] = src_q[j].last;
                        break;
                    end
                end
            end
            bus.in_valid = v;
            bus.in_data  = d;
            bus.in_last  = l;
            #2;
            mask = bus.in_ready & bus.in_valid;
        end
    end

    // Monitor: every output handshake is checked against the head of the expected queue.
    initial begin
        beat_t got, e;
        forever begin
            @(negedge clk); #3;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                got.ch   = bus.out_ch;
                got.data = bus.out_data;
                got.last = bus.out_last;
                xcyc.push_back(cyc);
                $display("beat cyc=%0d ch=%0d data=0x%02h last=%0b", cyc, got.ch, got.data, got.last);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", got, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(got == e, "beat", got, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;

        // Reset with every channel valid, then round robin 0..7 and wrap to 0.
        for (int k = 0; k < N_CH; k++) begin
            src_q.push_back(mk(k, k*16, 1'b1));
            exp_q.push_back(mk(k, k*16, 1'b1));
        end
        src_q.push_back(mk(0, 8'h01, 1'b1));
        exp_q.push_back(mk(0, 8'h01, 1'b1));
        repeat (3) @(posedge clk);
        #1;
        chk(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
        chk(bus.in_ready == '0, "rst_in_ready", bus.in_ready, 0);
        chk(bus.in_valid == '1, "rst_in_valid_driven", bus.in_valid, 8'hff);
        xcyc.delete();
        rst_n = 1'b1;
        wait_drain("rr");
        chk_span("rr_span", 9);

        // Backpressure: ch1 (0xA5) wins over ch3, held five cycles with out_ready low.
        xcyc.delete();
        bus.out_ready = 1'b0;
        src_q.push_back(mk(1, 8'hA5, 1'b1));
        src_q.push_back(mk(3, 8'h3C, 1'b1));
        exp_q.push_back(mk(1, 8'hA5, 1'b1));
        exp_q.push_back(mk(3, 8'h3C, 1'b1));
        wait_out_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            chk(bus.out_data == 8'hA5, "bp_hold_data", bus.out_data, 8'hA5);
            chk(bus.in_ready == '0, "bp_in_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_drain("bp");

        // Sparse: only ch7, next cycle only ch0; wrap with no idle cycle.
        xcyc.delete();
        src_q.push_back(mk(7, 8'h70, 1'b1));
        exp_q.push_back(mk(7, 8'h70, 1'b1));
        exp_q.push_back(mk(0, 8'h0C, 1'b1));
        @(posedge clk); #1;
        src_q.push_back(mk(0, 8'h0C, 1'b1));
        wait_drain("sparse");
        chk_span("sparse_span", 2);

        // Two 4-beat packets on ch2 and ch5 competing.
        xcyc.delete();
        for (int b = 0; b < 4; b++) src_q.push_back(mk(2, 8'h20 + b, b == 3));
        for (int b = 0; b < 4; b++) src_q.push_back(mk(5, 8'h50 + b, b == 3));
`ifdef STREAM_MUX_PKT_LOCK_EN
        for (int b = 0; b < 4; b++) exp_q.push_back(mk(2, 8'h20 + b, b == 3));
        for (int b = 0; b < 4; b++) exp_q.push_back(mk(5, 8'h50 + b, b == 3));
`else
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back(mk(2, 8'h20 + b, b == 3));
            exp_q.push_back(mk(5, 8'h50 + b, b == 3));
        end
`endif
        wait_drain("lock");
        chk_span("lock_span", 8);

        // Reset in the middle of a ch3 packet; ch0 must win afterwards.
        xcyc.delete();
        bus.out_ready = 1'b0;
        for (int b = 0; b < 4; b++) src_q.push_back(mk(3, 8'h30 + b, b == 3));
        wait_out_valid("rm_valid");
        chk(bus.out_ch == 3'd3, "rm_first_ch", bus.out_ch, 3);
        rst_n = 1'b0;
        #1;
        chk(bus.out_valid == 1'b0, "rm_out_valid", bus.out_valid, 0);
        chk(bus.in_ready == '0, "rm_in_ready", bus.in_ready, 0);
        src_q.push_back(mk(0, 8'h0A, 1'b1));
        exp_q.push_back(mk(0, 8'h0A, 1'b1));
        for (int b = 1; b < 4; b++) exp_q.push_back(mk(3, 8'h30 + b, b == 3));
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        wait_drain("rstmid");
        chk_span("rstmid_span", 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter: N_CH, 8, number of input channels; legal range 2..16.
REQ-002 Parameter: WIDTH, 8, data width per channel in bits.
REQ-003 Parameter: CHW, $clog2(N_CH), channel-index width; derived, never overridden.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port: in_valid  input  N_CH  per-channel valid.
REQ-008 Port: in_last  input  N_CH  per-channel end-of-packet marker, qualified by in_valid.
REQ-009 Port: in_ready  output  N_CH  per-channel ready; at most one bit high in any cycle.
REQ-010 Port: out_data  output  WIDTH  registered output data.
REQ-011 Port: out_valid  output  1  registered output valid.
REQ-012 Port: out_last  output  1  registered end-of-packet marker.
REQ-013 Port: out_ch  output  CHW  registered index of the source channel of the current beat.
REQ-014 Port: out_ready  input  1  downstream ready.

Function
REQ-015 A beat transfers on a channel k when in_valid[k] and in_ready[k] are both high at a rising edge; the output transfers when out_valid and out_ready are both high.
REQ-016 The output stage is a single register; it accepts a new beat when out_valid is low or out_ready is high; latency is exactly 1 cycle from input transfer to out_valid.
REQ-017 in_ready[k] is high only when the output stage accepts, channel k is granted, and in_valid[k] is high; in_ready does not depend combinationally on out_data.
REQ-018 Arbitration is round-robin: the search starts at (last_grant+1) mod N_CH and grants the first channel with in_valid high.
REQ-019 last_grant updates only on an input transfer; with no valid inputs no grant is made and last_grant holds.
REQ-020 States: IDLE (arbitrate every beat) and LOCKED (grant fixed to the locked channel); the state machine exists only when the macro in REQ-030 is defined.
REQ-021 IDLE to LOCKED on a transfer with in_last low; LOCKED to IDLE on a transfer from the locked channel with in_last high; a single-beat packet (in_last high on the first beat) stays in IDLE.
REQ-022 In LOCKED, other channels' in_valid is ignored; if the locked channel drops in_valid the grant is held and no transfer occurs.
REQ-023 Under continuous out_ready, full throughput (one beat per cycle) is sustained, including on back-to-back grant changes.
REQ-024 On out_ready low with out_valid high, out_data, out_last and out_ch hold stable and all in_ready bits are low.
REQ-025 last_grant wraps from N_CH-1 to 0; when N_CH is not a power of two, channel indices of N_CH or above are never granted.

Reset
REQ-026 While rst_n is low: out_valid=0, out_last=0, out_data=0, out_ch=0, in_ready=0, state=IDLE, last_grant=N_CH-1 (channel 0 wins first).
REQ-027 Reset asserted mid-packet discards the in-flight output beat and the lock; no partial-packet recovery.
REQ-028 Deassertion is synchronised externally; the first arbitration occurs on the first rising edge with rst_n high.

Configuration
REQ-029 Exactly one compile-time feature is selected by macro STREAM_MUX_PKT_LOCK_EN.
REQ-030 With STREAM_MUX_PKT_LOCK_EN defined, packet lock per REQ-020..022 applies; without it, there is no lock state, arbitration occurs every beat, and in_last is only registered to out_last.

Verification
REQ-031 Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, in_ready=0; after release, first out_ch=0.
REQ-032 Round-robin: N_CH=8, all in_valid=1, in_last=1, out_ready=1 -> out_ch sequence 0,1,...,7,0, one beat per cycle.
REQ-033 Backpressure: out_ready=0 for 5 cycles with out_valid=1, out_data=0xA5 -> out_data holds 0xA5, in_ready=0 throughout.
REQ-034 Lock (macro on): ch2 sends 4-beat packet while ch5 valid -> four ch2 beats, then ch5; with macro off the beats interleave 2,5,2,5.
REQ-035 Sparse: only ch7 valid, then only ch0 -> grants 7 then 0 (wrap), no idle cycle between them.
REQ-036 Reset mid-packet (macro on): assert rst_n low on beat 2 of a ch3 packet -> state=IDLE, out_valid=0; after release ch0 is granted first when valid.
